// File: rtl/fir_pkg.sv
// Shared constants for the 16-tap streaming FIR: tap count, coefficients,
// datapath growth and the run-control state encoding.
package fir_pkg;
    localparam int TAPS        = 16;
    localparam int DATA_W_DFLT = 32;
    localparam int PROD_GROW   = 4;
    localparam int SUM_GROW    = 8;
    localparam int PROD_W      = DATA_W_DFLT + PROD_GROW;
    localparam int SUM_W       = DATA_W_DFLT + SUM_GROW;

    localparam logic [3:0] COEF [TAPS] = '{
        4'd0, 4'd1, 4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int prod_w(input int data_w);
        return data_w + PROD_GROW;
    endfunction

    function automatic int sum_w(input int data_w);
        return data_w + SUM_GROW;
    endfunction
endpackage

// File: rtl/fir16_tap_pipe.sv
// Multiply (S2) and adder-tree (S3) stages of the FIR, carrying valid and zero tags.
// Latency: 2 cycles from window to sum. Backpressure: every stage holds while adv=0.
// Backpressure: no local stall logic; the caller's adv gates all registers.
module fir16_tap_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PROD_W = DATA_W + 4,
    parameter int SUM_W  = DATA_W + 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adv,
    input  logic                     v1,
    input  logic                     z1,
    input  logic signed [DATA_W-1:0] win [TAPS],
    output logic                     v3,
    output logic signed [SUM_W-1:0]  sum
);
    logic signed [PROD_W-1:0] prod [TAPS];
    logic                     v2;
    logic                     z2;
    logic signed [SUM_W-1:0]  sum_c;

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_c = sum_c + SUM_W'(prod[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2  <= 1'b0;
            z2  <= 1'b0;
            v3  <= 1'b0;
            sum <= '0;
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= '0;
            end
        end else if (adv) begin
            v2 <= v1;
            z2 <= z1;
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= PROD_W'(win[k]) * $signed(PROD_W'(COEF[k]));
            end
            v3  <= v2;
            // Partially filled windows must not leak stale history into the result.
            sum <= z2 ? '0 : sum_c;
        end
    end
endmodule

// File: rtl/fir16_stream.sv
// 16-tap streaming FIR (coefs 0..15) with run start/finish; FIR_SATURATE_EN selects saturating narrowing.
// Latency: accepted at edge t, output valid after edge t+3.
// Backpressure: input ready follows output ready through adv; all stages freeze when adv=0.
module fir16_stream
    import fir_pkg::*;
#(
    parameter int NUM_SAMPLES = 0,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    input  logic              input_fifo_valid_from_source,
    output logic              input_fifo_ready_to_source,
    input  logic [DATA_W-1:0] input_fifo_data_from_source,
    output logic              output_fifo_valid_to_sink,
    input  logic              output_fifo_ready_from_sink,
    output logic [DATA_W-1:0] output_fifo_data_to_sink
);
    localparam int          SW = sum_w(DATA_W);
    localparam logic [31:0] N  = 32'(NUM_SAMPLES);

    state_t                   state;
    logic [31:0]              in_cnt;
    logic [31:0]              out_cnt;
    logic [4:0]               fill;
    logic signed [DATA_W-1:0] win [TAPS];
    logic                     v1;
    logic                     z1;
    logic                     v3;
    logic signed [SW-1:0]     sum;
    logic [DATA_W-1:0]        narrow_dat;
    logic                     adv;
    logic                     accept;
    logic                     out_hs;

    assign adv    = !output_fifo_valid_to_sink || output_fifo_ready_from_sink;
    assign input_fifo_ready_to_source = (state == ST_RUN) && adv &&
                                        ((NUM_SAMPLES == 0) || (in_cnt < N));
    assign accept = input_fifo_valid_from_source && input_fifo_ready_to_source;
    assign out_hs = output_fifo_valid_to_sink && output_fifo_ready_from_sink;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            finish  <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) in_cnt <= in_cnt + 32'd1;
                    if (out_hs) begin
                        out_cnt <= out_cnt + 32'd1;
                        if ((NUM_SAMPLES > 0) && (out_cnt == N - 32'd1)) begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    finish <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    finish <= 1'b0;
                end
            endcase
        end
    end

    // S1: sample window, newest at the top; the zero tag marks the first 15 outputs.
    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE && start)) begin
            fill <= '0;
            v1   <= 1'b0;
            z1   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
        end else if (adv) begin
            v1 <= accept;
            z1 <= (fill < 5'd15);
            if (accept) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    win[k] <= win[k+1];
                end
                win[TAPS-1] <= $signed(input_fifo_data_from_source);
                if (fill != 5'd16) fill <= fill + 5'd1;
            end
        end
    end

    fir16_tap_pipe #(
        .DATA_W (DATA_W),
        .PROD_W (prod_w(DATA_W)),
        .SUM_W  (SW)
    ) u_tap_pipe (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .v1    (v1),
        .z1    (z1),
        .win   (win),
        .v3    (v3),
        .sum   (sum)
    );

`ifdef FIR_SATURATE_EN
    always_comb begin
        if ((&sum[SW-1:DATA_W-1]) || !(|sum[SW-1:DATA_W-1])) begin
            narrow_dat = sum[DATA_W-1:0];
        end else if (sum[SW-1]) begin
            narrow_dat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            narrow_dat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic sum_hi_unused;
    assign sum_hi_unused = ^sum[SW-1:DATA_W];
    assign narrow_dat    = sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            output_fifo_valid_to_sink <= 1'b0;
            output_fifo_data_to_sink  <= '0;
        end else if (adv) begin
            output_fifo_valid_to_sink <= v3;
            if (v3) output_fifo_data_to_sink <= narrow_dat;
        end
    end
endmodule
